// File: rtl/cordic_lin_div.sv
// Linear-vectoring CORDIC divider: q = num/den in signed fixed point, one
// iteration per clock, with divide-by-zero and range-overflow saturation.
module cordic_lin_div #(
   parameter int unsigned SIZE = 16,
   parameter int unsigned FRAC = 12,
   parameter int unsigned STG  = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            recip,
   input  logic [SIZE-1:0] num,
   input  logic [SIZE-1:0] den,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] q,
   output logic            dbz,
   output logic            ovf,
   output logic            busy
);
   localparam int unsigned XW = SIZE + 2;
   localparam int unsigned ZW = SIZE + 1;
   localparam int unsigned IW = (STG > 1) ? $clog2(STG) : 1;
   localparam logic [SIZE-1:0] Q_MAX = {1'b0, {(SIZE-1){1'b1}}};
   localparam logic [SIZE-1:0] Q_MIN = {1'b1, {(SIZE-1){1'b0}}};
   localparam logic [SIZE-1:0] N_ONE = SIZE'(1) << FRAC;
   localparam logic [ZW-1:0]   Z_ONE = ZW'(1) << FRAC;
   localparam logic [IW-1:0]   I_LAST = IW'(STG - 1);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   state_t state, state_nx;

   logic signed [XW-1:0] x, y, y_nx, x_sh, n_ext, d_ext;
   logic signed [ZW-1:0] z, z_nx;
   logic [ZW-1:0]        w;
   logic [XW-1:0]        n_abs, d_abs;
   logic [SIZE-1:0]      n_op, z_sat;
   logic [IW-1:0]        i;
   logic                 accept, last, den_zero, range_ovf, dir_sub;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (i == I_LAST);

   // Operand capture and exception classification at the accept edge
   always_comb begin
      n_op      = recip ? N_ONE : num;
      n_ext     = {{2{n_op[SIZE-1]}}, n_op};
      d_ext     = {{2{den[SIZE-1]}}, den};
      n_abs     = n_ext[XW-1] ? -n_ext : n_ext;
      d_abs     = d_ext[XW-1] ? -d_ext : d_ext;
      den_zero  = (den == '0);
      range_ovf = (n_abs >= (d_abs << 1));
   end

   // One vectoring step: drive y toward zero, accumulate quotient weight in z
   always_comb begin
      dir_sub = (y[XW-1] == x[XW-1]) || (y == '0);
      x_sh    = x >>> i;
      w       = Z_ONE >> i;
      y_nx    = dir_sub ? (y - x_sh) : (y + x_sh);
      z_nx    = dir_sub ? (z + $signed(w)) : (z - $signed(w));
      if (z_nx[ZW-1] != z_nx[ZW-2])
         z_sat = z_nx[ZW-1] ? Q_MIN : Q_MAX;
      else
         z_sat = z_nx[SIZE-1:0];
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = (den_zero || range_ovf) ? DONE : ITER;
         ITER:    if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x   <= '0;
         y   <= '0;
         z   <= '0;
         i   <= '0;
         q   <= '0;
         dbz <= 1'b0;
         ovf <= 1'b0;
      end else if (accept) begin
         x   <= d_ext;
         y   <= n_ext;
         z   <= '0;
         i   <= '0;
         dbz <= den_zero;
         ovf <= !den_zero && range_ovf;
         if (den_zero)
            q <= n_op[SIZE-1] ? Q_MIN : Q_MAX;
         else if (range_ovf)
            q <= (n_op[SIZE-1] ^ den[SIZE-1]) ? Q_MIN : Q_MAX;
      end else if (state == ITER) begin
         y <= y_nx;
         z <= z_nx;
         i <= i + IW'(1);
         if (last) q <= z_sat;
      end
   end
endmodule
